// File: rtl/fc_pkg.sv
// Shared types and helpers for the parallel fully-connected layer.
package fc_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } fc_state_e;

    // Accumulator wide enough that N products of two T-bit values cannot overflow.
    function automatic int acc_width(input int t, input int n);
        return 2 * t + $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Optional ReLU, then clamp into the signed t-bit range.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] acc,
                                                    input bit relu, input int t);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] v;
        hi = (64'sd1 <<< (t - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (t - 1));
        v  = (relu && acc < 0) ? 64'sd0 : acc;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One MAC lane: private weight bank (synchronous read), multiplier and
// clearable accumulator.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int T     = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int ACC_W = 34
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic signed [T-1:0]     wr_data,
    input  logic [AW-1:0]           rd_addr,
    input  logic                    clear,
    input  logic                    en,
    input  logic signed [T-1:0]     x,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [T-1:0]   bank [DEPTH];
    logic signed [T-1:0]   w_q;
    logic signed [2*T-1:0] prod;

    // Weight storage is never reset: contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en) bank[wr_addr] <= wr_data;
        w_q <= bank[rd_addr];
    end

    assign prod = (2*T)'(x) * (2*T)'(w_q);

    always_ff @(posedge clk) begin
        if (reset)      acc <= '0;
        else if (clear) acc <= '0;
        else if (en)    acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/fc_par_layer.sv
// Fully-connected layer y = W*x with P parallel MAC lanes, run-time weights,
// optional ReLU and saturating output, between two valid/ready streams.
module fc_par_layer
    import fc_pkg::*;
#(
    parameter int M    = 8,
    parameter int N    = 4,
    parameter int T    = 16,
    parameter int P    = 2,
    parameter int RELU = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     input_valid,
    output logic                     input_ready,
    input  logic signed [T-1:0]      input_data,
    output logic                     output_valid,
    input  logic                     output_ready,
    output logic signed [T-1:0]      output_data,
    input  logic                     w_wr_en,
    input  logic [$clog2(M*N)-1:0]   w_addr,
    input  logic signed [T-1:0]      w_data
);

    localparam int G     = M / P;
    localparam int DEPTH = G * N;
    localparam int BAW   = cnt_width(DEPTH);
    localparam int KW    = $clog2(N + 1);
    localparam int XW    = $clog2(N);
    localparam int GW    = cnt_width(G);
    localparam int LW    = cnt_width(P);
    localparam int ACC_W = acc_width(T, N);

    if (M % P != 0) begin : g_bad_mp
        $error("fc_par_layer: M must be a multiple of P");
    end
    if (N < 2) begin : g_bad_n
        $error("fc_par_layer: N must be at least 2");
    end

    fc_state_e               state;
    logic [KW-1:0]           k;
    logic [GW-1:0]           g;
    logic [LW-1:0]           lane;
    logic signed [T-1:0]     xbuf [N];
    logic signed [T-1:0]     x_q;
    logic                    acc_clear;
    logic                    acc_en;
    logic [BAW-1:0]          rd_addr;
    int                      w_row;
    int                      w_col;
    logic                    w_ok;
    logic [BAW-1:0]          bank_waddr;
    logic [P-1:0]            lane_we;
    logic signed [ACC_W-1:0] acc [P];
    logic signed [63:0]      post_val;
    logic                    unused_post_bits;

    // Valid/ready: a beat moves on the rising edge where valid && ready. Both
    // input_ready and output_valid decode only the registered state, so
    // neither depends on the other side's handshake input in the same cycle.
    assign input_ready  = (state == LOAD);
    assign output_valid = (state == OUTPUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
            k     <= '0;
            g     <= '0;
            lane  <= '0;
        end else begin
            unique case (state)
                LOAD: if (input_valid) begin
                    if (k == KW'(N - 1)) begin
                        k     <= '0;
                        g     <= '0;
                        state <= COMPUTE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                COMPUTE: if (k == KW'(N)) begin
                    k     <= '0;
                    lane  <= '0;
                    state <= OUTPUT;
                end else begin
                    k <= k + KW'(1);
                end
                OUTPUT: if (output_ready) begin
                    if (lane == LW'(P - 1)) begin
                        lane <= '0;
                        if (g == GW'(G - 1)) begin
                            state <= LOAD;
                        end else begin
                            g     <= g + GW'(1);
                            state <= COMPUTE;
                        end
                    end else begin
                        lane <= lane + LW'(1);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && input_valid) xbuf[k[XW-1:0]] <= input_data;
        if (k < KW'(N)) x_q <= xbuf[k[XW-1:0]];
    end

    // Cycle 0 of each group clears; cycles 1..N consume the reads issued one cycle earlier.
    assign acc_clear = (state == COMPUTE) && (k == '0);
    assign acc_en    = (state == COMPUTE) && (k != '0);
    assign rd_addr   = BAW'(int'(g) * N + int'(k));

    // Row r lives in bank r % P at index (r / P) * N + col.
    always_comb begin
        w_row      = int'(w_addr) / N;
        w_col      = int'(w_addr) % N;
        bank_waddr = BAW'((w_row / P) * N + w_col);
        w_ok       = w_wr_en && (state == LOAD) && (k == '0) && (int'(w_addr) < M * N);
    end

    for (genvar l = 0; l < P; l++) begin : g_lane
        assign lane_we[l] = w_ok && ((w_row % P) == l);

        fc_mac_lane #(
            .T     (T),
            .DEPTH (DEPTH),
            .AW    (BAW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (lane_we[l]),
            .wr_addr (bank_waddr),
            .wr_data (w_data),
            .rd_addr (rd_addr),
            .clear   (acc_clear),
            .en      (acc_en),
            .x       (x_q),
            .acc     (acc[l])
        );
    end

    assign post_val         = sat_relu(64'(acc[lane]), RELU != 0, T);
    assign output_data      = (state == OUTPUT) ? post_val[T-1:0] : '0;
    assign unused_post_bits = ^post_val[63:T];

endmodule

// File: tb/tb_fc_par_layer.sv
// Bench for fc_par_layer: a ReLU and a non-ReLU instance run in lockstep on
// shared stimulus and are scored against a plain-arithmetic y = W*x model.
`timescale 1ns/1ps
module tb_fc_par_layer;

  localparam int M       = 8;
  localparam int N       = 4;
  localparam int T       = 16;
  localparam int P       = 2;
  localparam int AW      = $clog2(M * N);
  localparam int BP_HOLD = 7;

  logic                clk = 1'b0;
  logic                reset;
  logic                input_valid;
  logic signed [T-1:0] input_data;
  logic                output_ready;
  logic                w_wr_en;
  logic [AW-1:0]       w_addr;
  logic signed [T-1:0] w_data;
  logic                in_ready0, in_ready1, out_valid0, out_valid1;
  logic signed [T-1:0] out_data0, out_data1;

  fc_par_layer #(.M(M), .N(N), .T(T), .P(P), .RELU(0)) dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(in_ready0), .input_data(input_data),
    .output_valid(out_valid0), .output_ready(output_ready), .output_data(out_data0),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data)
  );

  fc_par_layer #(.M(M), .N(N), .T(T), .P(P), .RELU(1)) dut_relu (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(in_ready1), .input_data(input_data),
    .output_valid(out_valid1), .output_ready(output_ready), .output_data(out_data1),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data)
  );

  int                  checks = 0;
  int                  errors = 0;
  int                  cyc = 0;
  logic [T-1:0]        exp_q[$];
  logic [T-1:0]        exp_relu_q[$];
  logic signed [T-1:0] wm [M*N];
  logic signed [T-1:0] xv [N];
  int                  ready_mode = 0;
  int                  hold_cnt = 0;
  int                  popped = 0;
  int                  beat_cyc = 0;
  logic                prev_stall = 1'b0;
  logic                ready_next = 1'b0;
  logic signed [T-1:0] held0, held1;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint ref_post(input longint s, input bit relu);
    longint hi, lo, v;
    hi = (longint'(1) <<< (T - 1)) - 1;
    lo = -hi - 1;
    v  = (relu && s < 0) ? 0 : s;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic push_expected();
    for (int r = 0; r < M; r++) begin
      longint s = 0;
      for (int c = 0; c < N; c++) s += longint'(wm[r*N + c]) * longint'(xv[c]);
      exp_q.push_back(T'(ref_post(s, 1'b0)));
      exp_relu_q.push_back(T'(ref_post(s, 1'b1)));
    end
  endtask

  function automatic logic signed [T-1:0] rnd(input int lim);
    return T'(int'($urandom_range(0, 2 * lim)) - lim);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_beat(input logic signed [T-1:0] d);
    int waited = 0;
    input_valid = 1'b1;
    input_data  = d;
    @(negedge clk);
    while (!in_ready0 && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 500) check("in_ready_timeout", longint'(in_ready0), 1);
    beat_cyc = cyc;
    @(posedge clk); #1;
    input_valid = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic signed [T-1:0] d);
    w_wr_en = 1'b1;
    w_addr  = AW'(addr);
    w_data  = d;
    @(posedge clk); #1;
    w_wr_en = 1'b0;
  endtask

  task automatic write_all();
    for (int a = 0; a < M * N; a++) do_write(a, wm[a]);
  endtask

  task automatic send_vec(input int gaps, input int wr_at, input int wr_a,
                          input logic signed [T-1:0] wr_v);
    push_expected();
    for (int i = 0; i < N; i++) begin
      if (i == wr_at) do_write(wr_a, wr_v);
      if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive_beat(xv[i]);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready0) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", longint'(exp_q.size()), 0);
  endtask

  // Downstream: 0 = always ready, 1 = random, 2 = each element stalled BP_HOLD cycles.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: output_ready = 1'b1;
      1: output_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (!out_valid0) begin
          output_ready = 1'b0;
          hold_cnt     = 0;
        end else if (output_ready) begin
          output_ready = 1'b0;
          hold_cnt     = 1;
        end else if (hold_cnt >= BP_HOLD) begin
          output_ready = 1'b1;
          hold_cnt     = 0;
        end else begin
          hold_cnt++;
        end
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      ready_next = 1'b0;
    end else begin
      if (ready_next) begin
        check("in_ready_after_last", longint'(in_ready0), 1);
        ready_next = 1'b0;
      end
      if (out_valid0) check("in_ready_busy", longint'(in_ready0), 0);
      if (out_valid0 && !output_ready) begin
        if (prev_stall) begin
          check("stall_stable", longint'(out_data0), longint'(held0));
          check("stall_stable_relu", longint'(out_data1), longint'(held1));
        end
        prev_stall = 1'b1;
        held0      = out_data0;
        held1      = out_data1;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid0 && output_ready) begin
        check("sb_nonempty", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          logic [T-1:0] e, er;
          e  = exp_q.pop_front();
          er = exp_relu_q.pop_front();
          check("y", longint'(out_data0), longint'($signed(e)));
          check("y_relu", longint'(out_data1), longint'($signed(er)));
          popped++;
          if (exp_q.size() == 0) ready_next = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, longint'(in_ready0), 1);
    check({tag, "_out_valid"}, longint'(out_valid0), 0);
    check({tag, "_out_data"}, longint'(out_data0), 0);
    check({tag, "_in_ready_relu"}, longint'(in_ready1), 1);
    check({tag, "_out_valid_relu"}, longint'(out_valid1), 0);
    check({tag, "_out_data_relu"}, longint'(out_data1), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int base;
    int ga;
    logic signed [T-1:0] gv;

    reset = 1'b1; input_valid = 1'b0; input_data = '0;
    w_wr_en = 1'b0; w_addr = '0; w_data = '0; output_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Identity weights plus first-output latency.
    for (int a = 0; a < M * N; a++) wm[a] = (((a / N) % 4) == (a % N)) ? 16'sd1 : 16'sd0;
    write_all();
    xv[0] = 16'sd5; xv[1] = -16'sd3; xv[2] = 16'sd7; xv[3] = 16'sd100;
    ready_mode = 0;
    send_vec(0, -1, 0, '0);
    n = 0;
    @(negedge clk);
    while (!out_valid0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("latency", longint'(cyc - beat_cyc), N + 2);
    wait_drain();

    // Saturation, both rails.
    for (int a = 0; a < M * N; a++) wm[a] = 16'sh7fff;
    write_all();
    for (int c = 0; c < N; c++) xv[c] = 16'sh7fff;
    send_vec(0, -1, 0, '0);
    wait_drain();
    for (int a = 0; a < M * N; a++) wm[a] = -16'sd32768;
    write_all();
    send_vec(0, -1, 0, '0);
    wait_drain();

    // ReLU pattern: row 0 all +1, row 1 all -1.
    for (int a = 0; a < M * N; a++) wm[a] = rnd(300);
    for (int c = 0; c < N; c++) begin
      wm[c]     = 16'sd1;
      wm[N + c] = -16'sd1;
      xv[c]     = T'(c + 1);
    end
    write_all();
    ready_mode = 1;
    send_vec(1, -1, 0, '0);
    wait_drain();

    // Backpressure on every output element.
    for (int a = 0; a < M * N; a++) wm[a] = rnd(500);
    write_all();
    for (int c = 0; c < N; c++) xv[c] = rnd(500);
    ready_mode = 2;
    send_vec(0, -1, 0, '0);
    wait_drain();

    // Random weights and vectors, alternating small and full-range values.
    ready_mode = 1;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < M * N; a++) wm[a] = rnd((it % 2 == 0) ? 1000 : 32768);
      write_all();
      for (int v = 0; v < 2; v++) begin
        for (int c = 0; c < N; c++) xv[c] = rnd((it % 2 == 0) ? 1000 : 32768);
        send_vec(1, -1, 0, '0);
        wait_drain();
      end
    end

    // Reset in the middle of group 1, then a fresh vector on the retained weights.
    for (int a = 0; a < M * N; a++) wm[a] = rnd(200);
    write_all();
    ready_mode = 0;
    for (int c = 0; c < N; c++) xv[c] = rnd(200);
    base = popped;
    send_vec(0, -1, 0, '0);
    n = 0;
    while (popped < base + P && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("group0_done", longint'(popped - base), P);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    exp_relu_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midop_reset");
    @(posedge clk); #1;
    for (int c = 0; c < N; c++) xv[c] = rnd(200);
    send_vec(0, -1, 0, '0);
    wait_drain();

    // Weight write gating: ignored mid-vector, honoured with no partial vector held.
    ready_mode = 1;
    for (int c = 0; c < N; c++) xv[c] = rnd(200);
    xv[1] = 16'sd9;
    ga = 3 * N + 1;
    gv = ~wm[ga];
    send_vec(0, 2, ga, gv);
    wait_drain();
    do_write(ga, gv);
    wm[ga] = gv;
    send_vec(0, -1, 0, '0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_par_layer.md
# fc_par_layer

Parametrised fully-connected layer computing y = W·x for an M×N signed weight matrix and an N-element input vector, with P parallel MAC lanes, run-time-loadable weights, optional ReLU and saturating output. It is the successor of the fixed-size, single-lane, ROM-weight FC layers. It sits between two valid/ready streams in the layer chain. Inputs stream in, the block computes in groups of P rows, and results stream out one element at a time in row order.

## Interface
- M, 8: output rows; M % P == 0 required (elaboration error otherwise)
- N, 4: input vector length, ≥ 2
- T, 16: signed data and weight width
- P, 2: parallel MAC lanes
- RELU, 0: 1 clamps negative results to 0 before output
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- input_valid  in  1  input element valid
- input_ready  out  1  block accepts input element
- input_data  in  T  signed input element
- output_valid  out  1  output element valid
- output_ready  in  1  downstream accepts output element
- output_data  out  T  signed output element
- w_wr_en  in  1  weight write strobe
- w_addr  in  clog2(M·N)  weight address = row·N + col
- w_data  in  T  signed weight value

## Operation
- States: LOAD, COMPUTE, OUTPUT.
- LOAD:
  - input_ready = 1.
  - Each input_valid&&input_ready beat writes x[k], with k counting 0..N-1.
  - After beat N-1: group g = 0, clear all accumulators, go to COMPUTE.
- COMPUTE:
  - Lasts exactly N+1 cycles.
  - Cycle c (0..N-1) issues read address k=c to the vector buffer and to each lane bank. Lane l reads weight row g·P+l, col k.
  - Reads are synchronous, 1 cycle.
  - At the end of cycles 1..N each lane does acc += x·w.
  - After cycle N, go to OUTPUT with lane index 0.
- OUTPUT:
  - output_valid = 1; output_data = post(acc[lane]).
  - On output_valid&&output_ready the lane index increments.
  - After lane P-1: if g < M/P-1, then g++, clear accumulators, go to COMPUTE. Otherwise go to LOAD.
- Output order: rows 0..M-1 ascending.
- Arithmetic:
  - Product 2T bits.
  - Accumulator 2T+clog2(N) bits; it cannot overflow.
  - post(): apply ReLU if RELU=1, then saturate to [-2^(T-1), 2^(T-1)-1].
- Weights:
  - Bank l holds rows r with r % P == l, at index (r/P)·N + col.
  - A write is honoured only in LOAD with k == 0 (no partial vector held); otherwise it is ignored.
  - A write is visible to the next computation.
  - Weight contents are undefined after power-up and are not cleared by reset.
- Input stalls in LOAD and output stalls in OUTPUT hold all state indefinitely.

## Timing
- Reset values:
  - state = LOAD, k = 0, g = 0, lane = 0.
  - input_ready = 1, output_valid = 0, output_data = 0, accumulators = 0.
- Reset in any state aborts the operation; partial vectors and results are discarded.
- input_ready and output_valid are registered-state decodes; neither depends combinationally on the other handshake input.
- Minimum latency, last input beat to first output_valid: N+2 cycles.
- Per-vector throughput, with no stalls: N + (M/P)·(N+1+P) cycles.
- input_ready = 0 throughout COMPUTE and OUTPUT; no overlap between vectors.
- output_data is stable while output_valid && !output_ready.

## Structure
- Package fc_pkg holds:
  - state enum typedef (LOAD, COMPUTE, OUTPUT);
  - function sat_relu(acc, RELU, T);
  - localparam helpers for accumulator width.
- Sub-module fc_mac_lane, instantiated P times. Each lane contains its weight bank (M/P·N × T synchronous RAM), multiplier and accumulator, with clear/enable inputs.
- Top level holds the FSM, counters k/g/lane, the N × T vector buffer, and the output mux.

## Test plan
- Identity (M=8, N=4, P=2, RELU=0):
  - W[r][c] = 1 if r % 4 == c, else 0; x = {5, -3, 7, 100}.
  - Expect outputs 5, -3, 7, 100, 5, -3, 7, 100.
  - First output_valid exactly 6 cycles after the last input beat.
- Saturation:
  - All W = 32767, x = {32767 ×4} → every output 32767.
  - W = -32768, x = 32767 → every output -32768.
- ReLU (RELU=1): W row 0 = {1,1,1,1}, row 1 = {-1,-1,-1,-1}, x = {1,2,3,4} → outputs 10, 0.
- Backpressure:
  - Hold output_ready = 0 for 7 cycles on each output.
  - output_data is stable and the sequence is unchanged.
  - input_ready stays 0 until the final handshake, then is 1 the next cycle.
- Reset mid-op:
  - Assert reset during COMPUTE of group 1 → next cycle all outputs at reset values.
  - A fresh vector then yields correct results with the retained weights.
- Weight write gating:
  - w_wr_en after 2 input beats is ignored.
  - The same write with k == 0 takes effect; check the resulting output.
